// File: rtl/instr_fetch_pkg.sv
// Shared CPU types for the fetch path: bus widths, fetch FSM states, buffer entry.
package instr_fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] dat;
  } fetch_entry_t;
endpackage

// File: rtl/prog_mem.sv
// 256x8 program memory: one synchronous write port, one read port with 1-cycle registered latency.
// No reset, so contents survive rst.
module prog_mem
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: load/run FSM, issues reads at the PC address into a DEPTH-entry
// first-word-fall-through buffer; pc_stall holds the PC whenever no read is issued.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic [ADDR_W-1:0] last_add,
  input  logic [ADDR_W-1:0] add,
  output logic              pc_stall,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_add,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_add,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              done
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state;
  fetch_entry_t      buf_q [DEPTH];
  fetch_entry_t      buf_d [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W:0]    occ;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_add;
  logic              last_issued;
  logic [DATA_W-1:0] rdata;
  logic              pop;
  logic              issue;
  logic              mem_we;

  assign instr_valid = (count_q != '0);
  assign instr       = buf_q[0].dat;
  assign instr_add   = buf_q[0].add;
  assign pop         = instr_valid && instr_ready;
  assign occ         = {1'b0, count_q} + (CNT_W+1)'(inflight);

  // A pop frees a slot this cycle, so a full buffer can still issue while draining.
  assign issue    = (state == S_RUN) && power && !last_issued &&
                    ((occ < (CNT_W+1)'(DEPTH)) || pop);
  assign pc_stall = !issue;
  assign mem_we   = ld_en && !rst && ((state == S_IDLE) || (state == S_LOAD));

  prog_mem u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ld_add),
    .wdata (ld_data),
    .re    (issue),
    .raddr (add),
    .rdata (rdata)
  );

  // Shift-register buffer: slot 0 is the head; the returning read lands after the survivors.
  always_comb begin
    count_d = count_q;
    wr_idx  = pop ? (count_q - CNT_W'(1)) : count_q;
    for (int i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
      buf_d[DEPTH-1] = '0;
      count_d        = count_q - CNT_W'(1);
    end
    if (inflight) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) buf_d[i] = '{add: inflight_add, dat: rdata};
      end
      count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count_q      <= '0;
      inflight     <= 1'b0;
      inflight_add <= '0;
      last_issued  <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_add <= add;
      if (issue && (add == last_add)) last_issued <= 1'b1;
      count_q <= count_d;
      buf_q   <= buf_d;

      case (state)
        S_IDLE: begin
          last_issued <= 1'b0;
          if (ld_en && !power)      state <= S_LOAD;
          else if (power && !ld_en) state <= S_RUN;
        end
        S_LOAD: begin
          if (!ld_en) state <= S_IDLE;
        end
        S_RUN: begin
          // Power loss wins over a simultaneous final accept: everything is flushed.
          if (!power) begin
            state    <= S_IDLE;
            count_q  <= '0;
            inflight <= 1'b0;
          end else if (pop && (instr_add == last_add)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!power) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
